watch_time_counter: RTL and testbench
=====================================

WATCH_TIME_COUNTER -- requirements
Module: watch_time_counter

Interface
REQ-001 SHALL have parameter none; all widths fixed (24-hour BCD time).
REQ-002 SHALL have port clk_i  input  1  system clock, 32.768 kHz crystal domain.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port hz_i  input  1  1 Hz square wave, registered in clk_i domain, resets high at its source.
REQ-005 SHALL have port set_mode_i  input  1  level; high = time-set mode.
REQ-006 SHALL have port inc_min_i  input  1  debounced button level; rising edge = minute increment.
REQ-007 SHALL have port inc_hour_i  input  1  debounced button level; rising edge = hour increment.
REQ-008 SHALL have port sec_u_o  output  4  seconds units BCD, 0-9.
REQ-009 SHALL have port sec_t_o  output  3  seconds tens BCD, 0-5.
REQ-010 SHALL have port min_u_o  output  4  minutes units BCD, 0-9.
REQ-011 SHALL have port min_t_o  output  3  minutes tens BCD, 0-5.
REQ-012 SHALL have port hour_u_o  output  4  hours units BCD, 0-9 (0-3 when tens=2).
REQ-013 SHALL have port hour_t_o  output  2  hours tens BCD, 0-2.
REQ-014 SHALL have port tick_o  output  1  registered one-cycle pulse per accepted 1 Hz rising edge.
REQ-015 SHALL have port day_o  output  1  registered one-cycle pulse on 23:59:59 -> 00:00:00 rollover.
REQ-016 SHALL have port set_o  output  1  registered; high while in SET state.

Function
REQ-017 SHALL register hz_i, inc_min_i and inc_hour_i once each; edge = current input 1 AND registered copy 0.
REQ-018 SHALL implement FSM states RUN and SET, state register output = set_o.
REQ-019 SHALL transition RUN->SET on the edge where set_mode_i=1, SET->RUN on the edge where set_mode_i=0.
REQ-020 SHALL on RUN->SET transition clear seconds to 00 at that same edge; minutes/hours unchanged.
REQ-021 SHALL in RUN, on the edge where an hz_i rising edge is detected, advance seconds by one and assert tick_o for the following cycle.
REQ-022 SHALL carry: sec 59->00 advances minutes; min 59->00 advances hours; hour 23->00 asserts day_o together with tick_o.
REQ-023 SHALL keep every BCD digit in legal range at all times; units 9->0 increments tens in same edge.
REQ-024 SHALL in SET ignore hz_i edges (no tick_o, seconds held 00).
REQ-025 SHALL in SET, on inc_min_i edge, increment minutes 59->00 without carry into hours.
REQ-026 SHALL in SET, on inc_hour_i edge, increment hours 23->00, no day_o.
REQ-027 SHALL apply simultaneous inc_min_i and inc_hour_i edges both in the same edge, independently.
REQ-028 SHALL ignore inc_min_i/inc_hour_i edges while in RUN.
REQ-029 SHALL, when hz_i edge coincides with the RUN->SET edge, discard the tick (seconds cleared, no tick_o).
REQ-030 SHALL, when set_mode_i falls, resume counting from 00 seconds; first tick after exit gives :01.
REQ-031 SHALL contain no combinational path from any input to any output.

Reset
REQ-032 SHALL on rst_i=1 asynchronously set all time digits 0, state RUN, tick_o=0, day_o=0, set_o=0.
REQ-033 SHALL reset hz_i, inc_min_i, inc_hour_i edge registers to 1 so inputs held high across reset release produce no edge.
REQ-034 SHALL treat reset mid-operation identically, including in SET state or during a pending edge.

Verification
REQ-035 Reset, hz_i toggled 60 full periods -> 00:01:00, exactly 60 tick_o pulses, each one clk_i cycle wide, no day_o.
REQ-036 Preload via SET to 23:59, exit, 60 hz_i rising edges -> 00:00:00, day_o and tick_o high same cycle, once.
REQ-037 SET mode, 61 inc_min_i edges from 00 -> minutes 01, hours unchanged; 25 inc_hour_i edges -> hours 01.
REQ-038 SET mode, inc_min_i and inc_hour_i rise same cycle from 12:59 -> 13:00 with hours also 13 (no minute carry), both applied.
REQ-039 RUN at 10:20:35, set_mode_i rises same cycle as hz_i edge -> 10:20:00, no tick_o, set_o=1 next cycle.
REQ-040 rst_i pulsed mid-SET with inc_hour_i held high, released -> 00:00:00, RUN, no increment until inc_hour_i falls and rises.

Source files
------------

// File: rtl/watch_time_counter.sv
// watch_time_counter: 24-hour BCD time-of-day counter with a RUN/SET mode FSM.
// A 1 Hz tick advances the time in RUN. In SET, the minute and hour buttons
// step their fields independently, and the seconds are held at 00.
module watch_time_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hz_i,
  input  logic       set_mode_i,
  input  logic       inc_min_i,
  input  logic       inc_hour_i,
  output logic [3:0] sec_u_o,
  output logic [2:0] sec_t_o,
  output logic [3:0] min_u_o,
  output logic [2:0] min_t_o,
  output logic [3:0] hour_u_o,
  output logic [1:0] hour_t_o,
  output logic       tick_o,
  output logic       day_o,
  output logic       set_o
);

  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

  state_t state;

  // Previous-cycle copies of the inputs, used for rising-edge detection
  logic hz_q, min_q, hour_q;
  logic hz_edge, min_edge, hour_edge;

  // Wrap at 59 and report the carry as {carry, tens, units}
  function automatic logic [7:0] inc60(input logic [2:0] t, input logic [3:0] u);
    if (u == 4'd9) begin
      if (t == 3'd5) inc60 = {1'b1, 3'd0, 4'd0};
      else           inc60 = {1'b0, t + 3'd1, 4'd0};
    end else begin
      inc60 = {1'b0, t, u + 4'd1};
    end
  endfunction

  // Wrap at 23 and report the carry as {carry, tens, units}
  function automatic logic [6:0] inc24(input logic [1:0] t, input logic [3:0] u);
    if (t == 2'd2 && u == 4'd3) inc24 = {1'b1, 2'd0, 4'd0};
    else if (u == 4'd9)         inc24 = {1'b0, t + 2'd1, 4'd0};
    else                        inc24 = {1'b0, t, u + 4'd1};
  endfunction

  logic [7:0] sec_nx, min_nx;
  logic [6:0] hour_nx;

  assign sec_nx    = inc60(sec_t_o, sec_u_o);
  assign min_nx    = inc60(min_t_o, min_u_o);
  assign hour_nx   = inc24(hour_t_o, hour_u_o);
  assign hz_edge   = hz_i & ~hz_q;
  assign min_edge  = inc_min_i & ~min_q;
  assign hour_edge = inc_hour_i & ~hour_q;
  assign set_o     = (state == SET);

  // Edge registers reset high, so an input that is held high across reset release is not seen as an edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hz_q   <= 1'b1;
      min_q  <= 1'b1;
      hour_q <= 1'b1;
    end else begin
      hz_q   <= hz_i;
      min_q  <= inc_min_i;
      hour_q <= inc_hour_i;
    end
  end

  // Mode FSM, time digits and the registered tick/day pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      sec_u_o  <= '0;
      sec_t_o  <= '0;
      min_u_o  <= '0;
      min_t_o  <= '0;
      hour_u_o <= '0;
      hour_t_o <= '0;
      tick_o   <= 1'b0;
      day_o    <= 1'b0;
    end else begin
      tick_o <= 1'b0;
      day_o  <= 1'b0;
      case (state)
        RUN: begin
          if (set_mode_i) begin
            // Entering SET drops any coincident tick and zeroes the seconds
            state   <= SET;
            sec_u_o <= '0;
            sec_t_o <= '0;
          end else if (hz_edge) begin
            tick_o  <= 1'b1;
            {sec_t_o, sec_u_o} <= sec_nx[6:0];
            if (sec_nx[7]) begin
              {min_t_o, min_u_o} <= min_nx[6:0];
              if (min_nx[7]) begin
                {hour_t_o, hour_u_o} <= hour_nx[5:0];
                day_o <= hour_nx[6];
              end
            end
          end
        end
        SET: begin
          if (!set_mode_i) begin
            state <= RUN;
          end else begin
            // Minutes and hours step independently; no carry between them
            if (min_edge)  {min_t_o, min_u_o}   <= min_nx[6:0];
            if (hour_edge) {hour_t_o, hour_u_o} <= hour_nx[5:0];
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_watch_time_counter.sv
// Bench for watch_time_counter. An integer time-of-day model predicts the
// outputs for every clock edge. The prediction goes into a scoreboard queue
// when the stimulus is driven, and it is popped and compared at the following
// falling edge. Scenario-level checks (tick/day counts, final times) are added
// on top of the per-cycle checks.
module tb_watch_time_counter;

  logic       clk = 1'b0;
  logic       rst, hz, set_mode, inc_min, inc_hour;
  logic [3:0] sec_u, min_u, hour_u;
  logic [2:0] sec_t, min_t;
  logic [1:0] hour_t;
  logic       tick, day, set_flag;

  watch_time_counter dut (
    .clk_i(clk), .rst_i(rst), .hz_i(hz), .set_mode_i(set_mode),
    .inc_min_i(inc_min), .inc_hour_i(inc_hour),
    .sec_u_o(sec_u), .sec_t_o(sec_t), .min_u_o(min_u), .min_t_o(min_t),
    .hour_u_o(hour_u), .hour_t_o(hour_t),
    .tick_o(tick), .day_o(day), .set_o(set_flag)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int tick_cnt = 0, day_cnt = 0, both_cnt = 0;

  // Model state
  int  mh, mm, ms;
  bit  mset, hzq, mq, hq;
  logic [22:0] sb[$];

  wire [19:0] time_v  = {hour_t, hour_u, min_t, min_u, sec_t, sec_u};
  wire [22:0] dut_vec = {time_v, tick, day, set_flag};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] bcd(input int h, input int m, input int s);
    bcd = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [22:0] pack_model(input bit tk, input bit dy);
    pack_model = {bcd(mh, mm, ms), tk, dy, mset};
  endfunction

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mset = 0;
    hzq = 1; mq = 1; hq = 1;
  endtask

  // One clock: predict the result of the coming edge, push it, then pop and compare after the edge
  task automatic step();
    bit hze, me, he, tk, dy;
    hze = hz && !hzq; me = inc_min && !mq; he = inc_hour && !hq;
    tk = 0; dy = 0;
    if (!mset) begin
      if (set_mode) begin
        mset = 1; ms = 0;
      end else if (hze) begin
        tk = 1; ms++;
        if (ms == 60) begin
          ms = 0; mm++;
          if (mm == 60) begin
            mm = 0; mh++;
            if (mh == 24) begin mh = 0; dy = 1; end
          end
        end
      end
    end else begin
      if (!set_mode) mset = 0;
      else begin
        if (me) mm = (mm + 1) % 60;
        if (he) mh = (mh + 1) % 24;
      end
    end
    hzq = hz; mq = inc_min; hq = inc_hour;
    sb.push_back(pack_model(tk, dy));
    @(posedge clk);
    @(negedge clk);
    chk("cycle", {9'd0, dut_vec}, {9'd0, sb.pop_front()});
    tick_cnt += int'(tick);
    day_cnt  += int'(day);
    if (tick && day) both_cnt++;
  endtask

  // Called at a falling edge: assert reset in the middle of the cycle and check that it acts before any clock edge
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 chk("rst_async", {9'd0, dut_vec}, {9'd0, pack_model(0, 0)});
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold", {9'd0, dut_vec}, {9'd0, pack_model(0, 0)});
    rst = 1'b0;
  endtask

  task automatic hz_pulse();
    hz = 1'b0; step(); step();
    hz = 1'b1; step(); step();
  endtask

  task automatic pmin(input int n);
    repeat (n) begin inc_min = 1'b1; step(); inc_min = 1'b0; step(); end
  endtask

  task automatic phour(input int n);
    repeat (n) begin inc_hour = 1'b1; step(); inc_hour = 1'b0; step(); end
  endtask

  initial begin
    rst = 1'b1; hz = 1'b1; set_mode = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 60 one-second periods from reset
    tick_cnt = 0; day_cnt = 0;
    repeat (60) hz_pulse();
    chk("run60_time", time_v, bcd(0, 1, 0));
    chk("run60_ticks", tick_cnt, 60);
    chk("run60_day", day_cnt, 0);

    // SET mode minute/hour wrap
    do_reset();
    set_mode = 1'b1; step();
    chk("set_enter", set_flag, 1);
    pmin(61);
    chk("set_min61", time_v, bcd(0, 1, 0));
    phour(25);
    chk("set_hour25", time_v, bcd(1, 1, 0));

    // Simultaneous increments from 12:59
    phour(11); pmin(58);
    chk("both_pre", time_v, bcd(12, 59, 0));
    inc_min = 1'b1; inc_hour = 1'b1; step();
    inc_min = 1'b0; inc_hour = 1'b0; step();
    chk("both_inc", time_v, bcd(13, 0, 0));

    // 1 Hz ignored while in SET
    tick_cnt = 0;
    repeat (3) hz_pulse();
    chk("set_no_tick", tick_cnt, 0);
    chk("set_hold", time_v, bcd(13, 0, 0));

    // Preload 23:59, run through midnight
    phour(10); pmin(59);
    set_mode = 1'b0; step();
    chk("day_pre", time_v, bcd(23, 59, 0));
    chk("day_run", set_flag, 0);
    tick_cnt = 0; day_cnt = 0; both_cnt = 0;
    repeat (60) hz_pulse();
    chk("day_time", time_v, bcd(0, 0, 0));
    chk("day_count", day_cnt, 1);
    chk("day_with_tick", both_cnt, 1);
    chk("day_ticks", tick_cnt, 60);

    // Buttons ignored in RUN
    pmin(2); phour(2);
    chk("run_ignore_btn", time_v, bcd(0, 0, 0));

    // Entering SET on the same edge as a tick at 10:20:35
    do_reset();
    set_mode = 1'b1; step();
    phour(10); pmin(20);
    set_mode = 1'b0; step();
    repeat (35) hz_pulse();
    chk("coinc_pre", time_v, bcd(10, 20, 35));
    hz = 1'b0; step();
    hz = 1'b1; set_mode = 1'b1; step();
    chk("coinc_time", time_v, bcd(10, 20, 0));
    chk("coinc_tick", tick, 0);
    chk("coinc_set", set_flag, 1);

    // Reset in the middle of SET with the hour button held high
    inc_hour = 1'b1; step();
    chk("rst_pre", time_v, bcd(11, 20, 0));
    do_reset();
    chk("rst_mid_time", time_v, bcd(0, 0, 0));
    chk("rst_mid_state", set_flag, 0);
    set_mode = 1'b1; step(); step();
    chk("held_no_inc", time_v, bcd(0, 0, 0));
    inc_hour = 1'b0; step();
    inc_hour = 1'b1; step();
    chk("held_then_edge", time_v, bcd(1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
